// File: rtl/hyperbus_wb_if.sv
// Signal bundle between a Wishbone classic master, the hyperbus_wb_bridge and a
// HyperBus controller. The bridge uses the slave view; the environment uses master.
interface hyperbus_wb_if;
    logic        wb_cyc_i;
    logic        wb_stb_i;
    logic        wb_we_i;
    logic [31:0] wb_adr_i;
    logic [31:0] wb_dat_i;
    logic [3:0]  wb_sel_i;
    logic [31:0] wb_dat_o;
    logic        wb_ack_o;
    logic        wb_err_o;

    logic [31:0] hb_adr_o;
    logic [15:0] hb_dat_o;
    logic        hb_reg_space_o;
    logic        hb_wrq_o;
    logic        hb_rrq_o;
    logic [15:0] hb_dat_i;
    logic        hb_ready_i;
    logic        hb_valid_i;
    logic        hb_busy_i;
    logic        hb_error_i;

    modport slave (
        input  wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_dat_i, wb_sel_i,
        input  hb_dat_i, hb_ready_i, hb_valid_i, hb_busy_i, hb_error_i,
        output wb_dat_o, wb_ack_o, wb_err_o,
        output hb_adr_o, hb_dat_o, hb_reg_space_o, hb_wrq_o, hb_rrq_o
    );

    modport master (
        output wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_dat_i, wb_sel_i,
        output hb_dat_i, hb_ready_i, hb_valid_i, hb_busy_i, hb_error_i,
        input  wb_dat_o, wb_ack_o, wb_err_o,
        input  hb_adr_o, hb_dat_o, hb_reg_space_o, hb_wrq_o, hb_rrq_o
    );
endinterface

// File: rtl/hyperbus_wb_bridge.sv
// Wishbone classic slave to HyperBus controller bridge: each 32-bit access is
// split into two 16-bit controller beats, with a progress timeout and drain phase.
module hyperbus_wb_bridge #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic         clk,
    input  logic         rstn,
    hyperbus_wb_if.slave bus
);
    localparam int unsigned CNT_W = 8;
    localparam int unsigned WB_W  = 32;
    localparam int unsigned HB_W  = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2,
        DRAIN = 2'd3
    } state_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              beat_q, beat_d;
    logic              wrq_q, wrq_d;
    logic              rrq_q, rrq_d;
    logic              ack_q, ack_d;
    logic              err_q, err_d;
    logic              reg_q, reg_d;
    logic [WB_W-1:0]   adr_q, adr_d;
    logic [WB_W-1:0]   rdat_q, rdat_d;
    logic [HB_W-1:0]   wdat_q, wdat_d;

    logic accept_c;
    logic progress_c;
    logic unused_adr0;

    // A response cycle blocks re-acceptance of the still-held strobe.
    assign accept_c   = bus.wb_cyc_i & bus.wb_stb_i & ~bus.hb_busy_i & ~bus.hb_error_i
                        & ~ack_q & ~err_q;
    assign progress_c = (state_q == WRITE) ? bus.hb_ready_i : bus.hb_valid_i;
    assign unused_adr0 = bus.wb_adr_i[0];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        beat_d  = beat_q;
        wrq_d   = wrq_q;
        rrq_d   = rrq_q;
        ack_d   = 1'b0;
        err_d   = 1'b0;
        reg_d   = reg_q;
        adr_d   = adr_q;
        rdat_d  = rdat_q;
        wdat_d  = wdat_q;

        case (state_q)
            IDLE: begin
                if (accept_c) begin
                    if (bus.wb_sel_i != 4'hF) begin
                        err_d = 1'b1;
                    end else begin
                        reg_d  = bus.wb_adr_i[31];
                        adr_d  = {2'b00, bus.wb_adr_i[30:1]};
                        cnt_d  = CNT_W'(TIMEOUT);
                        beat_d = 1'b0;
                        if (bus.wb_we_i) begin
                            state_d = WRITE;
                            wrq_d   = 1'b1;
                            wdat_d  = bus.wb_dat_i[15:0];
                        end else begin
                            state_d = READ;
                            rrq_d   = 1'b1;
                        end
                    end
                end
            end

            WRITE, READ: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (!bus.wb_cyc_i) begin
                    // Master abandoned the cycle: release silently.
                    wrq_d   = 1'b0;
                    rrq_d   = 1'b0;
                    state_d = DRAIN;
                end else if (bus.hb_error_i) begin
                    wrq_d   = 1'b0;
                    rrq_d   = 1'b0;
                    err_d   = 1'b1;
                    state_d = DRAIN;
                end else if (progress_c) begin
                    cnt_d  = CNT_W'(TIMEOUT);
                    beat_d = 1'b1;
                    if (state_q == WRITE) begin
                        wdat_d = bus.wb_dat_i[31:16];
                    end else if (beat_q) begin
                        rdat_d[31:16] = bus.hb_dat_i;
                    end else begin
                        rdat_d[15:0] = bus.hb_dat_i;
                    end
                    if (beat_q) begin
                        wrq_d   = 1'b0;
                        rrq_d   = 1'b0;
                        ack_d   = 1'b1;
                        state_d = DRAIN;
                    end
                end else if (cnt_q <= CNT_W'(1)) begin
                    wrq_d   = 1'b0;
                    rrq_d   = 1'b0;
                    err_d   = 1'b1;
                    state_d = DRAIN;
                end
            end

            DRAIN: begin
                wrq_d = 1'b0;
                rrq_d = 1'b0;
                if (!bus.hb_busy_i) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            beat_q  <= 1'b0;
            wrq_q   <= 1'b0;
            rrq_q   <= 1'b0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            reg_q   <= 1'b0;
            adr_q   <= '0;
            rdat_q  <= '0;
            wdat_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            beat_q  <= beat_d;
            wrq_q   <= wrq_d;
            rrq_q   <= rrq_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            reg_q   <= reg_d;
            adr_q   <= adr_d;
            rdat_q  <= rdat_d;
            wdat_q  <= wdat_d;
        end
    end

    assign bus.wb_dat_o       = rdat_q;
    assign bus.wb_ack_o       = ack_q;
    assign bus.wb_err_o       = err_q;
    assign bus.hb_adr_o       = adr_q;
    assign bus.hb_dat_o       = wdat_q;
    assign bus.hb_reg_space_o = reg_q;
    assign bus.hb_wrq_o       = wrq_q;
    assign bus.hb_rrq_o       = rrq_q;
endmodule

// File: doc/hyperbus_wb_bridge.md
HYPERBUS_WB_BRIDGE -- requirements
Module: hyperbus_wb_bridge

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255: cycles without hb_ready/hb_valid progress before a bus error.
REQ-002 SHALL have port clk  in  1  single clock; all logic on rising edge.
REQ-003 SHALL have port rstn  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have ports wb_cyc_i, wb_stb_i, wb_we_i  in  1 each  Wishbone classic slave cycle, strobe and write enable.
REQ-005 SHALL have ports wb_adr_i  in  32, wb_dat_i  in  32, wb_sel_i  in  4  Wishbone byte address, write data and byte selects.
REQ-006 SHALL have ports wb_dat_o  out  32, wb_ack_o  out  1, wb_err_o  out  1  Wishbone read data, acknowledge and error.
REQ-007 SHALL have ports hb_adr_o  out  32, hb_dat_o  out  16, hb_reg_space_o  out  1, hb_wrq_o  out  1, hb_rrq_o  out  1  controller request side.
REQ-008 SHALL have ports hb_dat_i  in  16, hb_ready_i  in  1, hb_valid_i  in  1, hb_busy_i  in  1, hb_error_i  in  1  controller response side.

Function
REQ-009 SHALL implement states IDLE, WRITE, READ, DRAIN.
REQ-010 In IDLE, a request SHALL be accepted when wb_cyc_i & wb_stb_i & !hb_busy_i & !hb_error_i.
REQ-011 SHALL respond to an accepted request with wb_sel_i != 4'hF by pulsing wb_err_o for 1 cycle, issuing no controller request and remaining in IDLE.
REQ-012 On acceptance, hb_reg_space_o SHALL take wb_adr_i[31] and hb_adr_o SHALL take {2'b00, wb_adr_i[30:1]} (16-bit word address), both held until return to IDLE.
REQ-013 On acceptance, wb_we_i=1 SHALL enter WRITE and assert hb_wrq_o; wb_we_i=0 SHALL enter READ and assert hb_rrq_o; both from the next cycle.
REQ-014 In WRITE, hb_dat_o SHALL be wb_dat_i[15:0] until the first cycle hb_ready_i=1, then wb_dat_i[31:16] for the second such cycle.
REQ-015 After the second hb_ready_i=1 cycle the bridge SHALL deassert hb_wrq_o, pulse wb_ack_o for 1 cycle and enter DRAIN.
REQ-016 In READ, the first hb_valid_i=1 cycle SHALL capture hb_dat_i into wb_dat_o[15:0], the second into wb_dat_o[31:16].
REQ-017 On the second hb_valid_i the bridge SHALL deassert hb_rrq_o, pulse wb_ack_o in the following cycle with wb_dat_o stable, and enter DRAIN.
REQ-018 Valid pulses SHALL be counted individually; non-adjacent pulses with gaps SHALL be accepted.
REQ-019 An 8-bit progress counter SHALL load TIMEOUT on entering WRITE/READ and reload on each hb_ready_i/hb_valid_i; reaching 0 SHALL drop the request, pulse wb_err_o (no ack) and enter DRAIN.
REQ-020 hb_error_i=1 in WRITE or READ SHALL drop the request, pulse wb_err_o and enter DRAIN.
REQ-021 wb_cyc_i falling in WRITE or READ SHALL drop the request, issue neither ack nor err, and enter DRAIN.
REQ-022 DRAIN SHALL hold both requests low and return to IDLE on the first cycle hb_busy_i=0.
REQ-023 wb_ack_o and wb_err_o SHALL be mutually exclusive, never high in the same cycle, and never high for more than 1 consecutive cycle.
REQ-024 hb_wrq_o and hb_rrq_o SHALL never be high simultaneously.
REQ-025 A new Wishbone strobe SHALL not be accepted in WRITE, READ or DRAIN; it waits for IDLE.

Reset
REQ-026 rstn=0 SHALL immediately force IDLE, and set hb_wrq_o, hb_rrq_o, wb_ack_o, wb_err_o, hb_reg_space_o to 0 and hb_adr_o, hb_dat_o, wb_dat_o to 0.
REQ-027 Reset asserted mid-transfer SHALL abandon it without ack or err; after release, operation resumes from IDLE.

Verification
REQ-028 Write adr=0x0000_1000, dat=0xCAFE_BABE, sel=F -> hb_adr_o=0x800, hb_wrq_o high; hb_dat_o=0xBABE on 1st ready, 0xCAFE on 2nd; ack 1 cycle; wrq low.
REQ-029 Read adr=0x8000_0002 with valid pulses 0x1234, gap of 3 cycles, 0x5678 -> hb_reg_space_o=1, hb_adr_o=0x1, wb_dat_o=0x5678_1234 with single ack.
REQ-030 Write with sel=4'h3 -> 1-cycle wb_err_o, hb_wrq_o never asserted.
REQ-031 Read with TIMEOUT=4 and no hb_valid_i -> rrq drops and wb_err_o pulses 4 cycles after the rrq rising edge; DRAIN until busy low.
REQ-032 wb_cyc_i dropped after the first ready of a write -> wrq drops, no ack/err; next request accepted only after hb_busy_i=0.
REQ-033 rstn low for 1 cycle during READ -> all outputs 0 asynchronously; a following read completes normally.
